// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared types and constants for the per-core warp launch path.
//  Revision    : 1.0
// ============================================================================
package gpu_pkg;

  // Lanes per warp when the instantiating core does not override it.
  localparam int WARP_SIZE_DEFAULT = 4;

  // Sentinel the dispatcher drives when no block is assigned.
  localparam logic signed [31:0] INVALID_BLOCK_ID = -32'sd1;

  // Launcher control states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } wl_state_t;

  // Warp descriptor as seen by the scheduler (default-width view).
  typedef struct packed {
    logic [31:0]                  base_tid;
    logic [15:0]                  idx;
    logic [WARP_SIZE_DEFAULT-1:0] mask;
  } warp_desc_t;

endpackage : gpu_pkg
`default_nettype wire

// File: rtl/lane_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lane_mask_gen
//  Description : Active-lane mask for warp k of a block with 'live' threads.
//                Lane i is active when k*WARP_SIZE + i < live.
//  Revision    : 1.0
// ============================================================================
module lane_mask_gen #(
  parameter int WARP_SIZE = 4
) (
  input  logic [31:0]          warp_k,
  input  logic [31:0]          live,
  output logic [WARP_SIZE-1:0] mask
);

  // 64-bit thread index so a large k never wraps into a false "active".
  for (genvar i = 0; i < WARP_SIZE; i++) begin : g_lane
    logic [63:0] w_tid;
    assign w_tid   = ({32'd0, warp_k} * 64'(WARP_SIZE)) + 64'(i);
    assign mask[i] = (w_tid < {32'd0, live});
  end

endmodule : lane_mask_gen
`default_nettype wire

// File: rtl/warp_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : warp_launcher
//  Description : Splits an assigned block into warps, issues them to the warp
//                scheduler over valid/ready, tracks outstanding warps and
//                reports done to the block dispatcher.
//  Revision    : 1.0
// ============================================================================
module warp_launcher
  import gpu_pkg::*;
#(
  parameter int WARP_SIZE = WARP_SIZE_DEFAULT,
  parameter int WIDX_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [31:0]   block_id,
  input  logic [31:0]          num_threads,
  input  logic [31:0]          block_dim,
  output logic                 warp_valid,
  input  logic                 warp_ready,
  output logic [31:0]          warp_base_tid,
  output logic [WIDX_W-1:0]    warp_idx,
  output logic [WARP_SIZE-1:0] warp_mask,
  input  logic                 warp_retire,
  output logic                 done,
  output logic                 err
);

  localparam int LOG2_WS = (WARP_SIZE > 1) ? $clog2(WARP_SIZE) : 0;

  wl_state_t            r_state;
  logic [31:0]          r_block_id;
  logic [31:0]          r_num_threads;
  logic [31:0]          r_block_dim;
  logic [31:0]          r_live;
  logic [31:0]          r_nwarps;
  logic [31:0]          r_k;
  logic [WIDX_W:0]      r_outstanding;

  logic [31:0]          w_base;
  logic [31:0]          w_avail;
  logic [31:0]          w_live;
  logic [32:0]          w_nwarps_wide;
  logic [31:0]          w_nwarps;
  logic                 w_xfer;
  logic [31:0]          w_k_next;
  logic                 w_last;
  logic [31:0]          w_mg_k;
  logic [31:0]          w_mg_live;
  logic [WARP_SIZE-1:0] w_mask;

  // Block geometry from the latched assignment; low 32 bits of the product
  // are the same for signed and unsigned operands.
  assign w_base  = r_block_id * r_block_dim;
  assign w_avail = r_num_threads - w_base;

  // Live thread count: zero for invalid ids, empty blocks or blocks past the end.
  always_comb begin
    w_live = 32'd0;
    if (!(r_block_id[31] || (r_block_dim == 32'd0) || (w_base >= r_num_threads))) begin
      w_live = (r_block_dim < w_avail) ? r_block_dim : w_avail;
    end
  end

  assign w_nwarps_wide = ({1'b0, w_live} + 33'(WARP_SIZE - 1)) >> LOG2_WS;
  assign w_nwarps      = w_nwarps_wide[31:0];

  assign w_xfer   = warp_valid && warp_ready;
  assign w_k_next = r_k + 32'd1;
  assign w_last   = (w_k_next == r_nwarps);

  // In SETUP the mask is for warp 0 of the freshly computed block; in ISSUE
  // it is for the warp that follows the one being transferred.
  assign w_mg_k    = (r_state == ST_SETUP) ? 32'd0  : w_k_next;
  assign w_mg_live = (r_state == ST_SETUP) ? w_live : r_live;

  lane_mask_gen #(
    .WARP_SIZE (WARP_SIZE)
  ) u_lane_mask_gen (
    .warp_k (w_mg_k),
    .live   (w_mg_live),
    .mask   (w_mask)
  );

  // Control FSM with registered descriptor, done, err and outstanding count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_block_id    <= 32'd0;
      r_num_threads <= 32'd0;
      r_block_dim   <= 32'd0;
      r_live        <= 32'd0;
      r_nwarps      <= 32'd0;
      r_k           <= 32'd0;
      r_outstanding <= '0;
      warp_valid    <= 1'b0;
      warp_base_tid <= 32'd0;
      warp_idx      <= '0;
      warp_mask     <= '0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      // Outstanding warps: a coincident issue and retire cancel out; a retire
      // with nothing outstanding is flagged and the count holds at zero.
      case ({w_xfer, warp_retire})
        2'b10: r_outstanding <= r_outstanding + (WIDX_W + 1)'(1);
        2'b01: begin
          if (r_outstanding == '0) begin
            err <= 1'b1;
          end else begin
            r_outstanding <= r_outstanding - (WIDX_W + 1)'(1);
          end
        end
        default: ;
      endcase

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_block_id    <= block_id;
            r_num_threads <= num_threads;
            r_block_dim   <= block_dim;
            r_state       <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_live   <= w_live;
          r_nwarps <= w_nwarps;
          r_k      <= 32'd0;
          if (w_live == 32'd0) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            warp_valid    <= 1'b1;
            warp_idx      <= '0;
            warp_base_tid <= w_base;
            warp_mask     <= w_mask;
            r_state       <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (w_xfer) begin
            if (w_last) begin
              warp_valid <= 1'b0;
              r_state    <= ST_DRAIN;
            end else begin
              r_k           <= w_k_next;
              warp_idx      <= w_k_next[WIDX_W-1:0];
              warp_base_tid <= warp_base_tid + 32'(WARP_SIZE);
              warp_mask     <= w_mask;
            end
          end
        end

        ST_DRAIN: begin
          if (r_outstanding == '0) begin
            done    <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Release only once the dispatcher lowers start, so one block is
          // reported exactly once.
          if (!start) begin
            done    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : warp_launcher
`default_nettype wire

// File: tb/tb_warp_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_warp_launcher
//  Description : Directed self-checking bench for warp_launcher with a
//                descriptor scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_warp_launcher;
  import gpu_pkg::*;

  localparam int WS = 4;
  localparam int WW = 16;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic signed [31:0] block_id;
  logic [31:0]       num_threads;
  logic [31:0]       block_dim;
  logic              warp_valid;
  logic              warp_ready;
  logic [31:0]       warp_base_tid;
  logic [WW-1:0]     warp_idx;
  logic [WS-1:0]     warp_mask;
  logic              warp_retire;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  // Expected descriptors: {base_tid, idx, mask}
  logic [51:0] sb[$];

  warp_launcher #(
    .WARP_SIZE (WS),
    .WIDX_W    (WW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .block_id      (block_id),
    .num_threads   (num_threads),
    .block_dim     (block_dim),
    .warp_valid    (warp_valid),
    .warp_ready    (warp_ready),
    .warp_base_tid (warp_base_tid),
    .warp_idx      (warp_idx),
    .warp_mask     (warp_mask),
    .warp_retire   (warp_retire),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] tid, input logic [15:0] idx, input logic [3:0] mask);
    sb.push_back({tid, idx, mask});
  endtask

  task automatic wait_valid_low();
    for (int i = 0; i < 30 && warp_valid; i++) step();
    chk("valid_drop", {63'd0, warp_valid}, 64'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30 && !done; i++) step();
    chk("done_rise", {63'd0, done}, 64'd1);
  endtask

  task automatic retire();
    warp_retire = 1'b1;
    step();
    warp_retire = 1'b0;
  endtask

  task automatic launch(input logic signed [31:0] bid, input logic [31:0] nt, input logic [31:0] bd);
    block_id    = bid;
    num_threads = nt;
    block_dim   = bd;
    start       = 1'b1;
  endtask

  // Scoreboard: every transfer must match the oldest expected descriptor.
  always @(negedge clk) begin
    if (rst_n && warp_valid && warp_ready) begin
      chk("warp_expected", {63'd0, sb.size() != 0}, 64'd1);
      if (sb.size() != 0) begin
        chk("warp_desc", {12'd0, warp_base_tid, warp_idx, warp_mask}, {12'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; block_id = '0; num_threads = '0; block_dim = '0;
    warp_ready = 1'b0; warp_retire = 1'b0;
    step(); step();
    chk("rst_valid", {63'd0, warp_valid}, 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_desc", {12'd0, warp_base_tid, warp_idx, warp_mask}, 64'd0);
    rst_n = 1'b1;
    step();

    // 1: two full warps
    push(32'd8, 16'd0, 4'b1111);
    push(32'd12, 16'd1, 4'b1111);
    warp_ready = 1'b1;
    launch(32'sd1, 32'd16, 32'd8);
    step();
    chk("t1_setup_valid", {63'd0, warp_valid}, 64'd0);
    step();
    chk("t1_first_valid", {63'd0, warp_valid}, 64'd1);
    wait_valid_low();
    chk("t1_drain_done", {63'd0, done}, 64'd0);
    chk("t1_outstanding", {47'd0, dut.r_outstanding}, 64'd2);
    retire();
    retire();
    wait_done();
    step();
    chk("t1_done_hold", {63'd0, done}, 64'd1);
    start = 1'b0;
    step();
    chk("t1_done_clear", {63'd0, done}, 64'd0);

    // 2: partial single warp
    push(32'd8, 16'd0, 4'b0011);
    launch(32'sd1, 32'd10, 32'd8);
    step(); step();
    wait_valid_low();
    retire();
    wait_done();
    chk("t2_err", {63'd0, err}, 64'd0);
    start = 1'b0;
    step();

    // 3: back-pressure keeps the descriptor stable
    push(32'd0, 16'd0, 4'b1111);
    push(32'd4, 16'd1, 4'b0011);
    warp_ready = 1'b0;
    launch(32'sd0, 32'd6, 32'd6);
    step(); step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_stable", {11'd0, warp_valid, warp_base_tid, warp_idx, warp_mask},
          {11'd0, 1'b1, 32'd0, 16'd0, 4'b1111});
      step();
    end
    warp_ready = 1'b1;
    wait_valid_low();
    retire();
    retire();
    wait_done();
    start = 1'b0;
    step();

    // 4a: invalid block id
    launch(INVALID_BLOCK_ID, 32'd16, 32'd8);
    step();
    chk("t4a_setup_done", {63'd0, done}, 64'd0);
    step();
    chk("t4a_done", {62'd0, done, warp_valid}, 64'd2);
    start = 1'b0;
    step();
    chk("t4a_done_clear", {63'd0, done}, 64'd0);

    // 4b: block beyond the thread range
    launch(32'sd2, 32'd16, 32'd8);
    step(); step();
    chk("t4b_done", {62'd0, done, warp_valid}, 64'd2);
    start = 1'b0;
    step();

    // 5: coincident transfer and retire, then a stray retire
    push(32'd8, 16'd0, 4'b1111);
    push(32'd12, 16'd1, 4'b1111);
    warp_ready = 1'b0;
    launch(32'sd1, 32'd16, 32'd8);
    step(); step();
    warp_ready = 1'b1;
    step();
    warp_ready = 1'b0;
    chk("t5_out_one", {47'd0, dut.r_outstanding}, 64'd1);
    warp_ready  = 1'b1;
    warp_retire = 1'b1;
    step();
    warp_retire = 1'b0;
    chk("t5_out_coincident", {47'd0, dut.r_outstanding}, 64'd1);
    chk("t5_no_err", {63'd0, err}, 64'd0);
    retire();
    wait_done();
    retire();
    chk("t5_err_set", {63'd0, err}, 64'd1);
    chk("t5_out_zero", {47'd0, dut.r_outstanding}, 64'd0);
    start = 1'b0;
    step(); step();
    chk("t5_err_sticky", {63'd0, err}, 64'd1);

    // 6: asynchronous reset mid-issue, then a fresh block
    push(32'd8, 16'd0, 4'b1111);
    warp_ready = 1'b0;
    launch(32'sd1, 32'd16, 32'd8);
    step(); step();
    warp_ready = 1'b1;
    step();
    warp_ready = 1'b0;
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ctrl", {61'd0, warp_valid, done, err}, 64'd0);
    chk("t6_async_desc", {12'd0, warp_base_tid, warp_idx, warp_mask}, 64'd0);
    chk("t6_async_out", {47'd0, dut.r_outstanding}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    push(32'd8, 16'd0, 4'b0011);
    warp_ready = 1'b1;
    launch(32'sd1, 32'd10, 32'd8);
    step(); step();
    chk("t6_restart_idx", {47'd0, warp_valid, warp_idx}, {47'd0, 1'b1, 16'd0});
    wait_valid_low();
    retire();
    wait_done();
    start = 1'b0;
    step();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_warp_launcher
`default_nettype wire

// File: doc/warp_launcher.md
Name: warp_launcher

Overview:
Per-core stage directly downstream of the block dispatcher: one instance per compute unit. Accepts a block assignment (start + block_id), splits the block's live threads into warps of WARP_SIZE lanes, and issues them to the core's warp scheduler over a valid/ready handshake. Counts outstanding warps, waits for all of them to retire, then raises done back to the dispatcher.

Parameters:
WARP_SIZE, 4, lanes per warp; power of two, >=1
WIDX_W, 16, width of the per-block warp index

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  dispatcher's core_start bit for this core
block_id  in  32  signed block id; negative = invalid
num_threads  in  32  kernel total threads
block_dim  in  32  kernel threads per block
warp_valid  out  1  warp descriptor valid
warp_ready  in  1  scheduler accepts descriptor
warp_base_tid  out  32  global thread id of lane 0
warp_idx  out  WIDX_W  warp index within block, from 0
warp_mask  out  WARP_SIZE  active lanes, bit i = lane i
warp_retire  in  1  one-cycle pulse: one issued warp finished
done  out  1  block complete; drives dispatcher core_done
err  out  1  sticky: retire with zero outstanding

Behaviour:
- Reset (async, rst_n=0): state IDLE; warp_valid=0, done=0, err=0, warp_base_tid=0, warp_idx=0, warp_mask=0, outstanding=0.
- States: IDLE, SETUP, ISSUE, DRAIN, DONE.
- IDLE: when start=1, latch block_id, num_threads, block_dim -> SETUP.
- SETUP (one cycle): base = block_id*block_dim (32-bit, modulo 2^32); live = 0 if block_id<0, block_dim=0 or base>=num_threads, else min(block_dim, num_threads-base); nwarps = ceil(live/WARP_SIZE). Go to DONE if live=0, else to ISSUE. The first warp_valid is asserted 2 cycles after start is sampled.
- ISSUE: warp_valid=1 with warp_idx=k, warp_base_tid=base+k*WARP_SIZE, warp_mask = lanes with k*WARP_SIZE+i < live.
  - Descriptor stays stable while warp_valid && !warp_ready.
  - On transfer (valid && ready): k++, outstanding++.
  - After the last transfer, warp_valid drops the next cycle and the state goes to DRAIN.
- DRAIN: when outstanding reaches 0, go to DONE.
- Retire:
  - warp_retire decrements outstanding in any state.
  - A transfer and a retire in the same cycle leave outstanding unchanged.
  - A retire with outstanding=0 (and no same-cycle transfer) sets err, and outstanding stays 0.
  - A retire may arrive during ISSUE; the block is complete only when all nwarps are issued and outstanding=0.
- DONE: done=1 (registered). done stays 1 while start=1. When start is sampled 0, go to IDLE with done=0 on the next edge, so done is low before the dispatcher can re-raise start, and a block is never double-counted.
- start dropping in SETUP/ISSUE/DRAIN is ignored; the block runs to completion and reports done.
- start held high in IDLE after DONE does not occur; if it does, it starts a new block.
- err clears only on reset.
- Outstanding counter width: WIDX_W+1.

Decomposition:
- Shared package gpu_pkg: WARP_SIZE default, INVALID_BLOCK_ID (-1), warp_launcher state enum, warp descriptor struct (base_tid, idx, mask).
- One natural sub-module: lane_mask_gen, combinational (warp k, live, WARP_SIZE) -> mask. Everything else stays in warp_launcher.

Test Plan:
1. num_threads=16, block_dim=8, block_id=1, warp_ready=1 -> warps (idx0, tid8, mask1111), (idx1, tid12, mask1111). Retire both -> done=1. Drop start -> done=0 next cycle.
2. num_threads=10, block_dim=8, block_id=1 -> single warp tid8, mask0011. Done after one retire.
3. num_threads=6, block_dim=6, block_id=0, warp_ready held 0 for 3 cycles -> descriptor tid0/mask1111 stable throughout. Then tid4, mask0011.
4. block_id=-1, or block_id=2 with num_threads=16, block_dim=8 -> no warp_valid. done=1 two cycles after start.
5. Transfer and retire in the same cycle, then an extra retire after done -> outstanding unchanged on the coincident cycle. err=1 and sticky.
6. rst_n pulsed low mid-ISSUE -> all outputs return to reset values asynchronously. A new start after reset issues from idx0.
